// File: rtl/puf_pkg.sv
// Shared types and defaults for the ring-oscillator PUF sequencer.
package puf_pkg;

  localparam int PUF_SEL_W     = 4;
  localparam int PUF_CNT_W     = 16;
  localparam int RO_MUX_INPUTS = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    COMPARE,
    DONE
  } puf_seq_state_t;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises an asynchronous oscillator, detects its rising edges and counts them
// (saturating) while enabled; clr forces the count back to zero.
module ro_edge_counter
  import puf_pkg::*;
#(
  parameter int CNT_W = PUF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ro,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [2:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise;

  // Stages 0/1 are the synchroniser; stage 2 is the previous synchronised value.
  assign w_rise = r_sync[1] & ~r_sync[2];
  assign o_cnt  = r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_ro};
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_en && w_rise && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF sequencer: walks the challenge pairs, counts both muxed ROs over a window
// and stores one comparison bit per pair. Define PUF_SEQ_RAW_CNT_EN to expose the raw counts.
module ro_puf_sequencer
  import puf_pkg::*;
#(
  parameter int SEL_W      = PUF_SEL_W,
  parameter int RESP_BITS  = 8,
  parameter int SETTLE_CYC = 8,
  parameter int WIN_CYC    = 1024,
  parameter int CNT_W      = PUF_CNT_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [RESP_BITS*2*SEL_W-1:0] i_challenge,
  input  logic                         i_ro_a,
  input  logic                         i_ro_b,
  output logic [SEL_W-1:0]             o_sel_a,
  output logic [SEL_W-1:0]             o_sel_b,
  output logic                         o_ro_en,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [RESP_BITS-1:0]         o_response,
`ifdef PUF_SEQ_RAW_CNT_EN
  output logic [CNT_W-1:0]             o_cnt_a,
  output logic [CNT_W-1:0]             o_cnt_b,
  output logic                         o_cnt_valid,
`endif
  output logic                         o_collision
);

  localparam int PAIR_W  = 2 * SEL_W;
  localparam int TMR_MAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int IDX_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_BITS - 1);

  puf_seq_state_t               r_state;
  logic [RESP_BITS*PAIR_W-1:0]  r_chal;
  logic [TMR_W-1:0]             r_tmr;
  logic [IDX_W-1:0]             r_idx;
  logic [SEL_W-1:0]             r_sel_a, r_sel_b;
  logic                         r_ro_en, r_busy, r_done, r_coll;
  logic [RESP_BITS-1:0]         r_resp;

  logic [CNT_W-1:0]             w_cnt_a, w_cnt_b;
  logic [PAIR_W-1:0]            w_pairs [RESP_BITS];
  logic [IDX_W-1:0]             w_nxt_idx;
  logic                         w_bit;

  always_comb begin
    for (int i = 0; i < RESP_BITS; i++) begin
      w_pairs[i] = r_chal[i*PAIR_W +: PAIR_W];
    end
  end

  assign w_nxt_idx = r_idx + 1'b1;
  // A pair that selects the same index on both muxes carries no entropy.
  assign w_bit     = (w_cnt_a > w_cnt_b) && (r_sel_a != r_sel_b);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_ro  (i_ro_a),
    .i_clr (r_state == SETTLE),
    .i_en  (r_state == COUNT),
    .o_cnt (w_cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_ro  (i_ro_b),
    .i_clr (r_state == SETTLE),
    .i_en  (r_state == COUNT),
    .o_cnt (w_cnt_b)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_chal  <= '0;
      r_tmr   <= '0;
      r_idx   <= '0;
      r_sel_a <= '0;
      r_sel_b <= '0;
      r_ro_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_coll  <= 1'b0;
      r_resp  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_chal  <= i_challenge;
            r_resp  <= '0;
            r_coll  <= 1'b0;
            r_idx   <= '0;
            r_tmr   <= '0;
            r_sel_a <= i_challenge[SEL_W-1:0];
            r_sel_b <= i_challenge[PAIR_W-1:SEL_W];
            r_ro_en <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_tmr == SETTLE_LAST) begin
            r_tmr   <= '0;
            r_state <= COUNT;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        COUNT: begin
          if (r_tmr == WIN_LAST) begin
            r_tmr   <= '0;
            r_ro_en <= 1'b0;
            r_state <= COMPARE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        COMPARE: begin
          r_resp[r_idx] <= w_bit;
          if (r_sel_a == r_sel_b) r_coll <= 1'b1;
          if (r_idx != IDX_LAST) begin
            r_idx   <= w_nxt_idx;
            r_sel_a <= w_pairs[w_nxt_idx][SEL_W-1:0];
            r_sel_b <= w_pairs[w_nxt_idx][PAIR_W-1:SEL_W];
            r_ro_en <= 1'b1;
            r_state <= SETTLE;
          end else begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_sel_a     = r_sel_a;
  assign o_sel_b     = r_sel_b;
  assign o_ro_en     = r_ro_en;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_response  = r_resp;
  assign o_collision = r_coll;

`ifdef PUF_SEQ_RAW_CNT_EN
  logic [CNT_W-1:0] r_raw_a, r_raw_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_raw_a <= '0;
      r_raw_b <= '0;
    end else if (r_state == COMPARE) begin
      r_raw_a <= w_cnt_a;
      r_raw_b <= w_cnt_b;
    end
  end

  // Live counts are final during COMPARE; afterwards the captured copies are shown.
  assign o_cnt_valid = (r_state == COMPARE);
  assign o_cnt_a     = o_cnt_valid ? w_cnt_a : r_raw_a;
  assign o_cnt_b     = o_cnt_valid ? w_cnt_b : r_raw_b;
`else
  // Raw window counts stay internal in this build.
`endif

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Directed bench for ro_puf_sequencer: models two 16-input oscillator muxes with fixed periods
// and checks responses, latency, collision, saturation, start-ignore and abort behaviour.
module tb_ro_puf_sequencer;

  localparam int RB  = 4;
  localparam int SC  = 4;
  localparam int WC  = 16;
  localparam int CW  = 8;
  localparam int SW  = 4;
  localparam int LAT = RB * (SC + WC + 1) + 1;
  localparam int PAIR_CYC = SC + WC + 1;

  // Oscillator half periods (clk period is 10); 0 means the oscillator is stuck low.
  localparam int HALF_A [16] = '{20, 30, 0, 10, 20, 20, 30, 30, 40, 40, 40, 40, 40, 40, 40, 40};
  localparam int HALF_B [16] = '{20, 30, 0, 10, 20, 40, 30, 30, 40, 40, 40, 40, 40, 40, 40, 40};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start_s = 1'b0;
  logic [RB*2*SW-1:0] chal = '0;
  logic [RB*2*SW-1:0] chal_s = '0;

  logic [15:0] osc_a, osc_b;
  logic        ro_a, ro_b, ro_a_s, ro_b_s;

  logic [SW-1:0] sel_a, sel_b, sel_a_s, sel_b_s;
  logic          ro_en, busy, done, coll, ro_en_s, busy_s, done_s, coll_s;
  logic [RB-1:0] resp, resp_s;
`ifdef PUF_SEQ_RAW_CNT_EN
  logic [CW-1:0] cnt_a, cnt_b;
  logic          cnt_valid;
  logic [2:0]    cnt_a_s, cnt_b_s;
  logic          cnt_valid_s;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  initial forever #5 clk = ~clk;

  for (genvar g = 0; g < 16; g++) begin : g_osc
    logic r_a = 1'b0;
    logic r_b = 1'b0;
    if (HALF_A[g] != 0) begin : g_a
      initial forever #(HALF_A[g]) r_a = ~r_a;
    end
    if (HALF_B[g] != 0) begin : g_b
      initial forever #(HALF_B[g]) r_b = ~r_b;
    end
    assign osc_a[g] = r_a;
    assign osc_b[g] = r_b;
  end

  assign ro_a   = ro_en & osc_a[sel_a];
  assign ro_b   = ro_en & osc_b[sel_b];
  assign ro_a_s = ro_en_s & osc_a[sel_a_s];
  assign ro_b_s = ro_en_s & osc_b[sel_b_s];

  ro_puf_sequencer #(
    .SEL_W(SW), .RESP_BITS(RB), .SETTLE_CYC(SC), .WIN_CYC(WC), .CNT_W(CW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_challenge (chal),
    .i_ro_a      (ro_a),
    .i_ro_b      (ro_b),
    .o_sel_a     (sel_a),
    .o_sel_b     (sel_b),
    .o_ro_en     (ro_en),
    .o_busy      (busy),
    .o_done      (done),
    .o_response  (resp),
`ifdef PUF_SEQ_RAW_CNT_EN
    .o_cnt_a     (cnt_a),
    .o_cnt_b     (cnt_b),
    .o_cnt_valid (cnt_valid),
`endif
    .o_collision (coll)
  );

  // Narrow counters to exercise saturation.
  ro_puf_sequencer #(
    .SEL_W(SW), .RESP_BITS(RB), .SETTLE_CYC(SC), .WIN_CYC(WC), .CNT_W(3)
  ) dut_sat (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start_s),
    .i_challenge (chal_s),
    .i_ro_a      (ro_a_s),
    .i_ro_b      (ro_b_s),
    .o_sel_a     (sel_a_s),
    .o_sel_b     (sel_b_s),
    .o_ro_en     (ro_en_s),
    .o_busy      (busy_s),
    .o_done      (done_s),
    .o_response  (resp_s),
`ifdef PUF_SEQ_RAW_CNT_EN
    .o_cnt_a     (cnt_a_s),
    .o_cnt_b     (cnt_b_s),
    .o_cnt_valid (cnt_valid_s),
`endif
    .o_collision (coll_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {16'd0, sel_a, sel_b, ro_en, busy, done, resp, coll};
  endfunction

  // Latency counts the IDLE cycle that samples start as cycle 1.
  task automatic run_main(input string name, input logic [31:0] c, input int restart_at,
                          output int lat);
    lat = 0;
    chal = c;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({name, "_busy"}, busy, 1);
    chk({name, "_ro_en"}, ro_en, 1);
    for (int n = 0; n < 200; n++) begin
      if (done) begin
        lat = n + 1;
        break;
      end
      if (n == 1) chk({name, "_resp_clr"}, resp, 0);
      if (n % PAIR_CYC == 1)
        chk($sformatf("%s_sel_pair%0d", name, n / PAIR_CYC), {sel_b, sel_a}, c[8*(n/PAIR_CYC) +: 8]);
      start = (n == restart_at);
      step();
    end
    start = 1'b0;
    chk({name, "_latency"}, lat, LAT);
    chk({name, "_ro_en_done"}, ro_en, 0);
    chk({name, "_busy_done"}, busy, 1);
  endtask

  initial begin
    int lat;
    logic seen;

    // Reset and idle
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("idle_outs_%0d", i), all_outs(), 0);
      step();
    end

    // Nominal: A faster on every pair
    run_main("nom", 32'h6085_7410, -1, lat);
    chk("nom_resp", resp, 4'b1111);
    chk("nom_coll", coll, 0);
    // start coincident with done is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    chk("nom_done_pulse", done, 0);
    chk("nom_start_in_done_busy", busy, 0);
    step();
    chk("nom_start_in_done_busy2", busy, 0);
    chk("nom_resp_held", resp, 4'b1111);

    // Tie on pair 0, A slower on pairs 1..3
    run_main("tie", 32'h4748_0140, -1, lat);
    chk("tie_resp", resp, 4'b0000);
    chk("tie_coll", coll, 0);
    step();

    // Collision on pair 2 (sel 5/5, A would win)
    run_main("col", 32'h6055_7410, -1, lat);
    chk("col_resp", resp, 4'b1011);
    chk("col_coll", coll, 1);
    step();

    // Second start mid-COUNT of pair 0 is ignored
    run_main("rst", 32'h6085_7410, 10, lat);
    chk("restart_resp", resp, 4'b1111);
    step();

    // Saturation: A toggles every clk (8 edges per window), B stuck low
    chal_s = 32'h2323_2323;
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
`ifdef PUF_SEQ_RAW_CNT_EN
      if (cnt_valid_s) chk("sat_cnt_a", cnt_a_s, 7);
`endif
      if (done_s) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("sat_done_seen", seen, 1);
    chk("sat_resp", resp_s, 4'b1111);
    step();

    // Abort with rst during COUNT of pair 1
    chal = 32'h6085_7410;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (PAIR_CYC + SC + 5) step();
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_outs", all_outs(), 0);
    seen = 1'b0;
    for (int n = 0; n < 120; n++) begin
      if (done || busy) seen = 1'b1;
      step();
    end
    chk("abort_no_done", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

endmodule
